dcache_unit: RTL and testbench
==============================

// Module: dcache_unit
// PURPOSE
//   Direct-mapped, write-through, no-write-allocate data cache. Serves the CPU MEM stage's
//   read/write requests: read hits complete in the request cycle; misses and all writes stall
//   the stage. Sits between the MEM stage and the main-memory port. Refills whole lines on
//   read misses and forwards every write to memory.
// PARAMETERS
//   INDEX_BITS  6   log2(number of lines); default 64 lines
//   WORD_BITS   2   log2(words per line); default 4 x 32-bit words
//   ADDR_W      32  byte-address width; tag = ADDR_W-INDEX_BITS-WORD_BITS-2
// PORTS
//   clk        in   1       system clock, rising edge
//   reset      in   1       asynchronous, active-high; clears all state
//   read       in   1       MEM-stage load request; held stable while stall=1
//   write      in   1       MEM-stage store request; held stable while stall=1
//   address    in   ADDR_W  byte address; bits [1:0] ignored (word aligned)
//   data_in    in   32      store data
//   data_out   out  32      load data; valid when read=1 and stall=0
//   hit        out  1       read or write request matches a valid line (combinational, IDLE only)
//   stall      out  1       request not yet complete; MEM stage freezes
//   mem_req    out  1       memory request; held until mem_ack
//   mem_we     out  1       1 = memory write, 0 = memory read
//   mem_addr   out  ADDR_W  word-aligned memory address
//   mem_wdata  out  32      memory write data
//   mem_rdata  in   32      memory read data; valid with mem_ack
//   mem_ack    in   1       one-cycle completion pulse; sampled only while mem_req=1
// BEHAVIOUR
//   Reset values: data_out=0, hit=0, stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
//     All valid bits cleared; FSM -> IDLE.
//   States: IDLE, REFILL, RESP, WRITE.
//   IDLE: hit = valid[idx] && tag[idx]==addr tag.
//     read && hit: data_out = line word; stall=0; no state change (0-cycle latency).
//     read && !hit: stall=1; -> REFILL; word counter = 0.
//     write: stall=1; if hit, update cached word this edge; latch addr/data; -> WRITE.
//     read && write together: treated as write. Neither asserted: stall=0, hit=0.
//   REFILL: mem_req=1, mem_we=0, mem_addr={tag,idx,cnt,2'b00}, stall=1.
//     Each mem_ack writes mem_rdata to word cnt; cnt++.
//     Ack on cnt=max: set valid and tag, capture requested word -> RESP.
//     Order: word 0 first (no critical-word-first).
//     Ack may arrive in the first cycle mem_req is high.
//     Line valid bit stays 0 until the last word lands.
//   RESP: stall=0, data_out = captured word, hit=0 -> IDLE.
//     Miss latency = 4 acks + 1 cycle.
//   WRITE: mem_req=1, mem_we=1, latched mem_addr/mem_wdata, stall=1.
//     On mem_ack -> IDLE with stall=0 that cycle; a miss does not allocate.
//   Index/tag wrap: a refill evicts the line unconditionally (no dirty state).
//     Same index, different tag is a miss.
//   Reset mid-REFILL/WRITE: request abandoned, mem_req drops immediately.
//     Memory side must tolerate an orphaned ack. Partial line stays invalid.
//   mem_ack outside REFILL/WRITE is ignored.
// STRUCTURE
//   Shared package dcache_defs: FSM state encoding, INDEX_BITS/WORD_BITS defaults,
//     tag/index/word field-extraction macros.
//   Sub-module dcache_array: valid/tag/data storage.
//     Combinational read port; synchronous word write; async valid clear on reset.
//   Top holds the FSM, word counter, latched request and memory-port drive.
// TESTING
//   1. Cold read 0x0000_0040; memory returns 0xA0..0xA3 with ack delay 2.
//      Expect 4 mem reads at 0x40,0x44,0x48,0x4C, then data_out=0xA0 in RESP,
//      then stall low.
//   2. Re-read 0x48 after test 1 -> hit=1, stall=0 same cycle, data_out=0xA2, mem_req stays 0.
//   3. Write 0xDEAD_BEEF to 0x44 (hit) -> mem write to 0x44.
//      Stall until ack; a later read of 0x44 returns 0xDEADBEEF with no refill.
//   4. Write to uncached 0x1000 -> mem write issued.
//      A following read of 0x1000 misses and refills (no allocate on write).
//   5. Conflict: read 0x40, then 0x40+(1<<(INDEX_BITS+WORD_BITS+2)).
//      Second read refills; read of 0x40 misses again.
//   6. Assert reset after the 2nd refill ack.
//      Expect mem_req=0 and stall=0 immediately; read 0x40 afterwards misses.

Source files
------------

// File: rtl/dcache_unit_pkg.sv
// Shared definitions for the direct-mapped write-through data cache:
// default geometry and the controller state encoding.
package dcache_unit_pkg;

    localparam int INDEX_BITS_DEF = 6;
    localparam int WORD_BITS_DEF  = 2;
    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W         = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_RESP   = 2'd2,
        ST_WRITE  = 2'd3
    } state_e;

    function automatic int tag_bits(input int addr_w, input int index_bits, input int word_bits);
        return addr_w - index_bits - word_bits - 2;
    endfunction

endpackage

// File: rtl/dcache_unit_if.sv
// Bundle of the MEM-stage request/response signals and the main-memory port.
// master = CPU stage plus memory, slave = the cache.
interface dcache_unit_if
    import dcache_unit_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              hit;
    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output read, write, address, data_in, mem_rdata, mem_ack,
        input  data_out, hit, stall, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  read, write, address, data_in, mem_rdata, mem_ack,
        output data_out, hit, stall, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_unit_array.sv
// Valid/tag/data storage: combinational lookup port, synchronous writes,
// valid bits cleared asynchronously on reset.
module dcache_unit_array
    import dcache_unit_pkg::*;
#(
    parameter int INDEX_BITS = INDEX_BITS_DEF,
    parameter int WORD_BITS  = WORD_BITS_DEF,
    parameter int TAG_W      = 22
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INDEX_BITS-1:0] rd_idx_i,
    input  logic [WORD_BITS-1:0]  rd_word_i,
    output logic                  rd_valid_o,
    output logic [TAG_W-1:0]      rd_tag_o,
    output logic [DATA_W-1:0]     rd_data_o,
    input  logic                  wr_en_i,
    input  logic [INDEX_BITS-1:0] wr_idx_i,
    input  logic [WORD_BITS-1:0]  wr_word_i,
    input  logic [DATA_W-1:0]     wr_data_i,
    input  logic                  fill_en_i,
    input  logic [INDEX_BITS-1:0] fill_idx_i,
    input  logic [TAG_W-1:0]      fill_tag_i,
    input  logic                  inval_en_i,
    input  logic [INDEX_BITS-1:0] inval_idx_i
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int WORDS = LINES << WORD_BITS;

    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  fill_sel;
    logic [LINES-1:0]  inval_sel;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [WORDS];

    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_line_sel
            assign fill_sel[gi]  = fill_en_i  && (fill_idx_i  == INDEX_BITS'(gi));
            assign inval_sel[gi] = inval_en_i && (inval_idx_i == INDEX_BITS'(gi));
        end
    endgenerate

    // A fill wins over an invalidate of the same line; the controller never issues both.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= (valid_q & ~inval_sel) | fill_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en_i) begin
            tag_mem[fill_idx_i] <= fill_tag_i;
        end
        if (wr_en_i) begin
            data_mem[{wr_idx_i, wr_word_i}] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_mem[rd_idx_i];
    assign rd_data_o  = data_mem[{rd_idx_i, rd_word_i}];

endmodule

// File: rtl/dcache_unit.sv
// Direct-mapped, write-through, no-write-allocate data cache controller:
// request decode, refill/write FSM and main-memory port drive.
module dcache_unit
    import dcache_unit_pkg::*;
#(
    parameter int INDEX_BITS = INDEX_BITS_DEF,
    parameter int WORD_BITS  = WORD_BITS_DEF,
    parameter int ADDR_W     = ADDR_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    dcache_unit_if.slave bus
);
    localparam int TAG_W = tag_bits(ADDR_W, INDEX_BITS, WORD_BITS);
    localparam int OFF_W = WORD_BITS + 2;

    logic [TAG_W-1:0]      req_tag;
    logic [INDEX_BITS-1:0] req_idx;
    logic [WORD_BITS-1:0]  req_word;

    logic                  rd_valid;
    logic [TAG_W-1:0]      rd_tag;
    logic [DATA_W-1:0]     rd_data;
    logic                  lookup_hit;

    logic                  wr_en;
    logic [INDEX_BITS-1:0] wr_idx;
    logic [WORD_BITS-1:0]  wr_word;
    logic [DATA_W-1:0]     wr_data;
    logic                  fill_en;
    logic                  inval_en;

    state_e                state_q;
    logic [WORD_BITS-1:0]  cnt_q;
    logic [WORD_BITS-1:0]  cnt_inc;
    logic                  last_word;
    logic [TAG_W-1:0]      tag_q;
    logic [INDEX_BITS-1:0] idx_q;
    logic [WORD_BITS-1:0]  word_q;
    logic [DATA_W-1:0]     resp_q;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic [ADDR_W-1:0]     mem_addr_q;
    logic [DATA_W-1:0]     mem_wdata_q;

    assign req_tag  = bus.address[ADDR_W-1 -: TAG_W];
    assign req_idx  = bus.address[OFF_W +: INDEX_BITS];
    assign req_word = bus.address[2 +: WORD_BITS];

    dcache_unit_array #(
        .INDEX_BITS (INDEX_BITS),
        .WORD_BITS  (WORD_BITS),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk         (clk),
        .reset       (reset),
        .rd_idx_i    (req_idx),
        .rd_word_i   (req_word),
        .rd_valid_o  (rd_valid),
        .rd_tag_o    (rd_tag),
        .rd_data_o   (rd_data),
        .wr_en_i     (wr_en),
        .wr_idx_i    (wr_idx),
        .wr_word_i   (wr_word),
        .wr_data_i   (wr_data),
        .fill_en_i   (fill_en),
        .fill_idx_i  (idx_q),
        .fill_tag_i  (tag_q),
        .inval_en_i  (inval_en),
        .inval_idx_i (req_idx)
    );

    assign lookup_hit = rd_valid && (rd_tag == req_tag);
    assign cnt_inc    = cnt_q + WORD_BITS'(1);
    assign last_word  = (cnt_q == {WORD_BITS{1'b1}});

    // Store hits patch the cached word in IDLE; refill acks stream words into the line.
    always_comb begin
        wr_en    = 1'b0;
        wr_idx   = req_idx;
        wr_word  = req_word;
        wr_data  = bus.data_in;
        fill_en  = 1'b0;
        inval_en = 1'b0;
        if (state_q == ST_IDLE) begin
            wr_en    = bus.write && lookup_hit;
            inval_en = bus.read && !bus.write && !lookup_hit;
        end else if (state_q == ST_REFILL && bus.mem_ack) begin
            wr_en   = 1'b1;
            wr_idx  = idx_q;
            wr_word = cnt_q;
            wr_data = bus.mem_rdata;
            fill_en = last_word;
        end
    end

    always_comb begin
        bus.hit      = 1'b0;
        bus.stall    = 1'b0;
        bus.data_out = '0;
        case (state_q)
            ST_IDLE: begin
                bus.hit   = (bus.read || bus.write) && lookup_hit;
                bus.stall = bus.write || (bus.read && !lookup_hit);
                if (bus.read && !bus.write && lookup_hit) begin
                    bus.data_out = rd_data;
                end
            end
            ST_REFILL: bus.stall = 1'b1;
            ST_RESP:   bus.data_out = resp_q;
            ST_WRITE:  bus.stall = !bus.mem_ack;
            default:   bus.stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            tag_q       <= '0;
            idx_q       <= '0;
            word_q      <= '0;
            resp_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.write) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= {bus.address[ADDR_W-1:2], 2'b00};
                        mem_wdata_q <= bus.data_in;
                        state_q     <= ST_WRITE;
                    end else if (bus.read && !lookup_hit) begin
                        tag_q      <= req_tag;
                        idx_q      <= req_idx;
                        word_q     <= req_word;
                        cnt_q      <= '0;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= {req_tag, req_idx, {WORD_BITS{1'b0}}, 2'b00};
                        state_q    <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (bus.mem_ack) begin
                        if (cnt_q == word_q) begin
                            resp_q <= bus.mem_rdata;
                        end
                        if (last_word) begin
                            mem_req_q <= 1'b0;
                            state_q   <= ST_RESP;
                        end else begin
                            cnt_q      <= cnt_inc;
                            mem_addr_q <= {tag_q, idx_q, cnt_inc, 2'b00};
                        end
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
                ST_WRITE: begin
                    if (bus.mem_ack) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dcache_unit.sv
// Scoreboard bench for dcache_unit: directed scenarios plus randomized traffic,
// checked against a memory-image / resident-line reference model.
module tb_dcache_unit;
    import dcache_unit_pkg::*;

    localparam int ADDR_W     = 32;
    localparam int INDEX_BITS = 6;
    localparam int WORD_BITS  = 2;
    localparam int LINES      = 1 << INDEX_BITS;
    localparam int WPL        = 1 << WORD_BITS;
    localparam int OFF_W      = WORD_BITS + 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dcache_unit_if #(.ADDR_W(ADDR_W)) bus ();

    dcache_unit #(
        .INDEX_BITS (INDEX_BITS),
        .WORD_BITS  (WORD_BITS),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        is_read;
        logic        exp_hit;
        logic [31:0] exp_data;
        logic [31:0] addr;
    } rsp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } mop_t;

    rsp_t rsp_q[$];
    mop_t mop_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] backing [logic [31:0]];
    logic [31:0] resident_line [LINES];
    logic        resident_v    [LINES];

    int fixed_delay = -1;
    int wait_cnt    = 0;
    int ack_count   = 0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    function automatic int next_delay();
        if (fixed_delay >= 0) return fixed_delay;
        return int'($urandom_range(0, 3));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) resident_v[i] = 1'b0;
    endtask

    // Reference: memory is always the truth (write-through); the cache only decides hit/miss.
    task automatic model_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] wa;
        logic [31:0] la;
        int          idx;
        logic        h;
        wa  = a & ~32'h3;
        la  = a >> OFF_W;
        idx = int'(la % LINES);
        if (wr) begin
            mop_q.push_back('{we: 1'b1, addr: wa, data: d});
            ref_mem[wa] = d;
            rsp_q.push_back('{is_read: 1'b0, exp_hit: 1'b0, exp_data: 32'h0, addr: wa});
        end else if (rd) begin
            h = resident_v[idx] && (resident_line[idx] == la);
            if (!h) begin
                for (int w = 0; w < WPL; w++)
                    mop_q.push_back('{we: 1'b0, addr: (la << OFF_W) + 32'(w * 4), data: 32'h0});
                resident_v[idx]    = 1'b1;
                resident_line[idx] = la;
            end
            rsp_q.push_back('{is_read: 1'b1, exp_hit: h, exp_data: ref_rd(wa), addr: wa});
        end
    endtask

    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        bit done;
        model_req(rd, wr, a, d);
        @(posedge clk);
        #1;
        bus.read    = rd;
        bus.write   = wr;
        bus.address = a;
        bus.data_in = d;
        done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (!bus.stall) done = 1;
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL req_timeout: addr 0x%08h still stalled, required completion", a);
        end
        @(posedge clk);
        #1;
        bus.read  = 1'b0;
        bus.write = 1'b0;
    endtask

    // CPU-side monitor
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (!reset && (bus.read || bus.write) && !bus.stall) begin
                if (rsp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL cpu_unexpected: completion at addr 0x%08h, required none", bus.address);
                end else begin
                    e = rsp_q.pop_front();
                    if (e.is_read) begin
                        check("rd_data", bus.data_out, e.exp_data);
                        check("rd_hit", 32'(bus.hit), 32'(e.exp_hit));
                        $display("cpu rd  addr=0x%08h data=0x%08h hit=%0b", e.addr, bus.data_out, bus.hit);
                    end else begin
                        $display("cpu wr  addr=0x%08h done", e.addr);
                    end
                end
            end
        end
    end

    // Memory responder and memory-side monitor
    initial begin
        mop_t  m;
        logic [31:0] a;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            bus.mem_ack = 1'b0;
            if (reset) begin
                wait_cnt = next_delay();
            end else if (bus.mem_req) begin
                if (wait_cnt > 0) begin
                    wait_cnt--;
                end else begin
                    a = bus.mem_addr;
                    bus.mem_ack = 1'b1;
                    ack_count++;
                    if (bus.mem_we) backing[a] = bus.mem_wdata;
                    else bus.mem_rdata = backing.exists(a) ? backing[a] : init_word(a);
                    if (mop_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL mem_spurious: request we=%0b addr=0x%08h, required none", bus.mem_we, a);
                    end else begin
                        m = mop_q.pop_front();
                        check("mem_we", 32'(bus.mem_we), 32'(m.we));
                        check("mem_addr", a, m.addr);
                        if (m.we) check("mem_wdata", bus.mem_wdata, m.data);
                    end
                    $display("mem %s addr=0x%08h data=0x%08h", bus.mem_we ? "wr" : "rd", a,
                             bus.mem_we ? bus.mem_wdata : bus.mem_rdata);
                    wait_cnt = next_delay();
                end
            end
        end
    end

    initial begin
        int base;
        bit seen;
        logic [31:0] a;
        int op;
        bus.read    = 1'b0;
        bus.write   = 1'b0;
        bus.address = '0;
        bus.data_in = '0;
        model_clear();
        for (int w = 0; w < WPL; w++) begin
            backing[32'h40 + 32'(w * 4)] = 32'hA0 + 32'(w);
            ref_mem[32'h40 + 32'(w * 4)] = 32'hA0 + 32'(w);
        end

        #3;
        check("rst_data_out", bus.data_out, 32'h0);
        check("rst_hit", 32'(bus.hit), 32'h0);
        check("rst_stall", 32'(bus.stall), 32'h0);
        check("rst_mem_req", 32'(bus.mem_req), 32'h0);
        check("rst_mem_we", 32'(bus.mem_we), 32'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        #20;
        reset = 1'b0;

        fixed_delay = 2;
        do_req(1, 0, 32'h0000_0040, 0);     // cold miss, returns 0xA0
        fixed_delay = -1;
        do_req(1, 0, 32'h0000_0048, 0);     // hit, 0xA2
        do_req(0, 1, 32'h0000_0044, 32'hDEAD_BEEF);
        do_req(1, 0, 32'h0000_0044, 0);     // hit, 0xDEADBEEF
        do_req(0, 1, 32'h0000_1000, 32'h1234_5678);
        do_req(1, 0, 32'h0000_1000, 0);     // miss: no allocate on write
        do_req(1, 0, 32'h0000_0040, 0);
        do_req(1, 0, 32'h0000_0440, 0);     // conflict eviction
        do_req(1, 0, 32'h0000_0040, 0);     // misses again
        do_req(1, 1, 32'h0000_0048, 32'h0BAD_F00D);  // read+write acts as write

        // Reset in the middle of a refill, right after the second ack.
        model_req(1, 0, 32'h0000_0840, 0);
        @(posedge clk);
        #1;
        bus.read    = 1'b1;
        bus.address = 32'h0000_0840;
        base = ack_count;
        seen = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(posedge clk);
            if (ack_count >= base + 2) seen = 1;
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL refill_acks: saw %0d acks, required 2", ack_count - base);
        end
        #1;
        reset    = 1'b1;
        bus.read = 1'b0;
        #2;
        check("midrst_mem_req", 32'(bus.mem_req), 32'h0);
        check("midrst_stall", 32'(bus.stall), 32'h0);
        rsp_q.delete();
        mop_q.delete();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        do_req(1, 0, 32'h0000_0040, 0);     // valid bits cleared: miss

        for (int i = 0; i < 150; i++) begin
            a  = (32'($urandom_range(0, 1)) << 10) | (32'($urandom_range(0, 2)) << OFF_W)
               | (32'($urandom_range(0, WPL - 1)) << 2) | 32'($urandom_range(0, 3));
            op = int'($urandom_range(0, 9));
            if (op < 6)      do_req(1, 0, a, 0);
            else if (op < 9) do_req(0, 1, a, $urandom);
            else             do_req(1, 1, a, $urandom);
        end

        repeat (5) @(posedge clk);
        #3;
        check("rsp_q_drained", 32'(rsp_q.size()), 32'h0);
        check("mop_q_drained", 32'(mop_q.size()), 32'h0);
        check("idle_mem_req", 32'(bus.mem_req), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
